dmem_responder: RTL



---
 rtl/smachine_pkg.sv | 26 ++
 rtl/dmem_responder_if.sv | 31 +++
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_responder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/smachine_pkg.sv
// ============================================================================
// Module   : smachine_pkg
// Brief    : Shared types and constants for the S-Machine data-memory path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package smachine_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [7:0] MMIO_CNT_ADDR = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module   : dmem_responder_if
// Brief    : CPU data-memory req/ready bus; master = CPU, slave = responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dmem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req;
    logic              read_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              err;

    modport master (
        output req, read_write, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  req, read_write, addr, wdata,
        output rdata, ready, err
    );
endinterface

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module   : dmem_array
// Brief    : Single-port DEPTH x DATA_W store, registered read, no reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read-first behaviour; no reset so the store maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Clocked data-memory responder with programmable wait states.
//            Optional MMIO cycle counter at the top address: DMEM_CYCLE_COUNTER_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

import smachine_pkg::*;

module dmem_responder #(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_responder_if.slave       bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dmem_state_t       state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              in_range;
    logic              is_mmio;
    logic              arr_we;
    logic [AW-1:0]     arr_addr;
    logic [DATA_W-1:0] arr_rdata;
    logic [DATA_W-1:0] resp_rdata;
    logic [DATA_W-1:0] rdata_now;

    assign in_range = (32'(addr_q) < 32'(DEPTH));

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [DATA_W-1:0] cyc_q, cyc_d;

    assign is_mmio = (addr_q == ADDR_W'(MMIO_CNT_ADDR));

    always_comb begin
        cyc_d = cyc_q + DATA_W'(1);
        if (state_q == RESP && rw_q == RW_WRITE && is_mmio) begin
            cyc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    always_comb begin
        resp_rdata = arr_rdata;
        if (is_mmio) begin
            resp_rdata = cyc_q;
        end else if (!in_range) begin
            resp_rdata = '0;
        end
    end
`else
    assign is_mmio = 1'b0;

    always_comb begin
        resp_rdata = arr_rdata;
        if (!in_range) begin
            resp_rdata = '0;
        end
    end
`endif

    // In IDLE the array is addressed by the live bus so a zero-wait read
    // still has its data registered by the time RESP begins.
    assign arr_addr = (state_q == IDLE) ? bus.addr[AW-1:0] : addr_q[AW-1:0];
    assign arr_we   = (state_q == RESP) && (rw_q == RW_WRITE) && in_range && !is_mmio;

    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_array (
        .clk    (clk),
        .we     (arr_we),
        .addr   (arr_addr),
        .wdata  (wdata_q),
        .rdata  (arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    rw_d    = bus.read_write;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        wcnt_d  = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data is shown live during RESP and held afterwards until the next read.
    assign rdata_now = (state_q == RESP && rw_q == RW_READ) ? resp_rdata : rdata_q;
    assign rdata_d   = rdata_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rw_q    <= RW_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata = rdata_now;
    assign bus.ready = (state_q == RESP);
    assign bus.err   = (state_q == RESP) && !in_range && !is_mmio;

endmodule

`default_nettype wire
